pipeline_stall_controller: RTL

Central stall/flush sequencer for the 5-stage pipeline. It combines the hazard unit's hazard_detected, the EXE-stage branch decision and the MEM-stage memory wait into per-register freeze/flush controls. It drives the hazard unit's disable input and runs a post-reset boot hold. It keeps saturating performance counters and a sticky memory-timeout flag.

---
 rtl/pipeline_stall_controller_pkg.sv | 7 +
 rtl/pipeline_stall_controller_sat_counter.sv | 17 +
 rtl/pipeline_stall_controller.sv | 64 ++++++
 3 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// pipeline_stall_controller_pkg: shared FSM state type and default sizing for the stall controller.
package pipeline_stall_controller_pkg;
  typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT} state_t;
  localparam int BOOT_CYCLES_DEF = 4;
  localparam int MEM_TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  logic [W-1:0] count_d, count_q;
  always_comb count_d = clr ? '0 : (inc && count_q != '1) ? count_q + W'(1) : count_q;
  always_ff @(posedge clk)
    if (rst) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: merges hazard, branch and memory-wait into freeze/flush controls,
// with a post-reset boot hold, saturating perf counters and a sticky memory-timeout flag.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int BOOT_CYCLES = BOOT_CYCLES_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             freeze_all,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             hdu_disable,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_hz_cnt,
  output logic [CNT_W-1:0] stall_mem_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  state_t state_d, state_q;
  logic [7:0] boot_cnt_d, boot_cnt_q;
  logic [15:0] wait_cnt_d, wait_cnt_q;
  logic mem_timeout_d, mem_timeout_q;
  logic boot, mem_stall, br, hz;
  always_comb begin
    boot = state_q == BOOT;
    mem_stall = ((state_q == RUN) & mem_req & ~mem_ready) | ((state_q == MEM_WAIT) & ~mem_ready);
    // priority: memory stall > branch flush > hazard stall
    br = branch_taken & ~mem_stall & ~boot;
    hz = hazard_detected & ~mem_stall & ~branch_taken & ~boot;
    freeze_all = boot | mem_stall;
    freeze_if_id = boot | mem_stall | hz;
    flush_if_id = boot | br;
    flush_id_exe = boot | br | hz;
    hdu_disable = boot;
    state_d = boot ? ((boot_cnt_q == 8'(BOOT_CYCLES - 1)) ? RUN : BOOT) : mem_stall ? MEM_WAIT : RUN;
    boot_cnt_d = boot ? boot_cnt_q + 8'd1 : boot_cnt_q;
    wait_cnt_d = !mem_stall ? 16'd0 : (wait_cnt_q == 16'hffff) ? wait_cnt_q : wait_cnt_q + 16'd1;
    mem_timeout_d = mem_timeout_q | (mem_stall & (wait_cnt_q == 16'(MEM_TIMEOUT - 1)));
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= BOOT;
      boot_cnt_q <= '0;
      wait_cnt_q <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      boot_cnt_q <= boot_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  assign mem_timeout = mem_timeout_q;
  sat_counter #(.W(CNT_W)) u_hz_cnt (.clk(clk), .rst(rst), .inc(hz), .clr(cnt_clr), .count(stall_hz_cnt));
  sat_counter #(.W(CNT_W)) u_mem_cnt (.clk(clk), .rst(rst), .inc(mem_stall), .clr(cnt_clr), .count(stall_mem_cnt));
  sat_counter #(.W(CNT_W)) u_fl_cnt (.clk(clk), .rst(rst), .inc(br), .clr(cnt_clr), .count(flush_cnt));
endmodule
